// File: rtl/pe_ab_stream_loader.sv
// pe_ab_stream_loader: per-PE A/B operand loader with a ping-pong A-slice buffer,
// A/B forwarding down the PE chain and a valid/ready pair stream to the MAC.
module pe_ab_stream_loader #(
    parameter int D_WIDTH  = 64,
    parameter int PE_NUM   = 4,
    parameter int PE_COUNT = 4,
    parameter int PID      = 0,
    parameter int B_NUM    = 8,
    parameter int FWD_EN   = 1,
    localparam int AW = PE_NUM > 1 ? $clog2(PE_NUM) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [D_WIDTH-1:0] data_A_FIFO_in,
    input  logic               valid_A_FIFO_in,
    output logic               RD_EN_A_FIFO_out,
    output logic [D_WIDTH-1:0] data_A_FIFO_out,
    output logic               WR_EN_A_FIFO_out,
    input  logic               full_A_FIFO_in,
    input  logic [D_WIDTH-1:0] data_B_FIFO_in,
    input  logic               valid_B_FIFO_in,
    output logic               RD_EN_B_FIFO_out,
    output logic [D_WIDTH-1:0] data_B_FIFO_out,
    output logic               WR_EN_B_FIFO_out,
    input  logic               full_B_FIFO_in,
    output logic [D_WIDTH-1:0] data_A_out,
    output logic [D_WIDTH-1:0] data_B_out,
    output logic [AW-1:0]      a_idx_out,
    output logic               valid_AB_out,
    input  logic               ready_AB_in,
    output logic               last_AB_out
);
    localparam int unsigned ATOT = PE_NUM * PE_COUNT;
    localparam int CW = ATOT > 1 ? $clog2(ATOT) : 1;
    localparam int BW = B_NUM > 1 ? $clog2(B_NUM) : 1;
    localparam int unsigned LO = PID * PE_NUM;

    typedef enum logic [1:0] {IDLE, FETCH_B, EMIT} state_t;

    state_t             state;
    logic [D_WIDTH-1:0] bank [2][PE_NUM];
    logic [1:0]         full, full_set, full_clr;
    logic               load_bank, rd_bank;
    logic [CW-1:0]      cnt_a;
    logic [BW-1:0]      b_cnt;
    logic [AW-1:0]      a_idx;
    logic [D_WIDTH-1:0] b_lat;
    logic [31:0]        off;
    logic               in_slice, load_done, release_bank, emit, fire, a_last, b_last;

    // Offset into this PE's slice; wraps huge for words before the slice.
    assign off       = 32'(cnt_a) - LO;
    assign in_slice  = off < 32'(PE_NUM);
    assign RD_EN_A_FIFO_out = !rst && valid_A_FIFO_in && !full[load_bank] && (FWD_EN == 0 || !full_A_FIFO_in);
    assign RD_EN_B_FIFO_out = !rst && state == FETCH_B && valid_B_FIFO_in && (FWD_EN == 0 || !full_B_FIFO_in);
    assign load_done = RD_EN_A_FIFO_out && 32'(cnt_a) == ATOT - 1;
    assign emit      = state == EMIT;
    assign fire      = emit && ready_AB_in;
    assign a_last    = a_idx == AW'(PE_NUM - 1);
    assign b_last    = b_cnt == BW'(B_NUM - 1);
    assign release_bank = fire && a_last && b_last;
    assign full_set  = {load_done && load_bank, load_done && !load_bank};
    assign full_clr  = {release_bank && rd_bank, release_bank && !rd_bank};

    assign valid_AB_out = emit;
    assign data_A_out   = emit ? bank[rd_bank][a_idx] : '0;
    assign data_B_out   = emit ? b_lat : '0;
    assign a_idx_out    = emit ? a_idx : '0;
    assign last_AB_out  = emit && a_last && b_last;

    // Bank storage needs no reset: the full flags gate every read.
    always_ff @(posedge clk) begin
        if (RD_EN_A_FIFO_out && in_slice) bank[load_bank][AW'(off)] <= data_A_FIFO_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            full             <= '0;
            load_bank        <= 1'b0;
            rd_bank          <= 1'b0;
            cnt_a            <= '0;
            b_cnt            <= '0;
            a_idx            <= '0;
            b_lat            <= '0;
            data_A_FIFO_out  <= '0;
            WR_EN_A_FIFO_out <= 1'b0;
            data_B_FIFO_out  <= '0;
            WR_EN_B_FIFO_out <= 1'b0;
        end else begin
            WR_EN_A_FIFO_out <= FWD_EN != 0 && RD_EN_A_FIFO_out;
            WR_EN_B_FIFO_out <= FWD_EN != 0 && RD_EN_B_FIFO_out;
            if (RD_EN_A_FIFO_out) begin
                data_A_FIFO_out <= data_A_FIFO_in;
                cnt_a           <= load_done ? '0 : cnt_a + CW'(1);
            end
            if (RD_EN_B_FIFO_out) data_B_FIFO_out <= data_B_FIFO_in;
            if (load_done) load_bank <= !load_bank;
            full <= (full | full_set) & ~full_clr;
            case (state)
                IDLE: if (full[rd_bank]) state <= FETCH_B;
                FETCH_B: if (RD_EN_B_FIFO_out) begin
                    b_lat <= data_B_FIFO_in;
                    state <= EMIT;
                end
                EMIT: if (ready_AB_in) begin
                    a_idx <= a_last ? '0 : a_idx + AW'(1);
                    if (a_last) begin
                        b_cnt <= b_last ? '0 : b_cnt + BW'(1);
                        state <= b_last ? IDLE : FETCH_B;
                        if (b_last) rd_bank <= !rd_bank;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_ab_stream_loader.sv
// tb_pe_ab_stream_loader: two loaders (forwarding PE and last PE) fed from modelled FIFOs,
// checked against a block/slice arithmetic model of the expected pair and forward streams.
module tb_pe_ab_stream_loader;
    localparam int DW = 16, PN = 2, PC = 2, PID = 1, BN = 2, AT = PN * PC, M = 1023;

    logic clk = 1'b0, rst;
    logic va [2], vb [2], full_a [2], full_b [2], rdy [2];
    logic [DW-1:0] dai [2], dbi [2];
    logic rd_a [2], wr_a [2], rd_b [2], wr_b [2], val [2], last [2];
    logic [DW-1:0] fa_d [2], fb_d [2], da [2], db [2];
    logic [0:0] idx [2];

    logic [DW-1:0] aw [2][1024];
    logic [DW-1:0] bw [2][1024];
    int a_wr [2], b_wr [2], a_rd [2], b_rd [2], a_base [2], b_base [2];
    int fa_n [2], fb_n [2], pair_n [2], a_pop [2], tgt [2], fgen [2], fseen [2];
    bit pend_a [2], pend_b [2], popa [2], popb [2], hold [2], rel [2];
    logic [63:0] held [2];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    pe_ab_stream_loader #(.D_WIDTH(DW), .PE_NUM(PN), .PE_COUNT(PC), .PID(PID), .B_NUM(BN), .FWD_EN(1)) dut0 (
        .clk(clk), .rst(rst),
        .data_A_FIFO_in(dai[0]), .valid_A_FIFO_in(va[0]), .RD_EN_A_FIFO_out(rd_a[0]),
        .data_A_FIFO_out(fa_d[0]), .WR_EN_A_FIFO_out(wr_a[0]), .full_A_FIFO_in(full_a[0]),
        .data_B_FIFO_in(dbi[0]), .valid_B_FIFO_in(vb[0]), .RD_EN_B_FIFO_out(rd_b[0]),
        .data_B_FIFO_out(fb_d[0]), .WR_EN_B_FIFO_out(wr_b[0]), .full_B_FIFO_in(full_b[0]),
        .data_A_out(da[0]), .data_B_out(db[0]), .a_idx_out(idx[0]),
        .valid_AB_out(val[0]), .ready_AB_in(rdy[0]), .last_AB_out(last[0]));

    pe_ab_stream_loader #(.D_WIDTH(DW), .PE_NUM(PN), .PE_COUNT(PC), .PID(PID), .B_NUM(BN), .FWD_EN(0)) dut1 (
        .clk(clk), .rst(rst),
        .data_A_FIFO_in(dai[1]), .valid_A_FIFO_in(va[1]), .RD_EN_A_FIFO_out(rd_a[1]),
        .data_A_FIFO_out(fa_d[1]), .WR_EN_A_FIFO_out(wr_a[1]), .full_A_FIFO_in(full_a[1]),
        .data_B_FIFO_in(dbi[1]), .valid_B_FIFO_in(vb[1]), .RD_EN_B_FIFO_out(rd_b[1]),
        .data_B_FIFO_out(fb_d[1]), .WR_EN_B_FIFO_out(wr_b[1]), .full_B_FIFO_in(full_b[1]),
        .data_A_out(da[1]), .data_B_out(db[1]), .a_idx_out(idx[1]),
        .valid_AB_out(val[1]), .ready_AB_in(rdy[1]), .last_AB_out(last[1]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor on the falling edge, FIFO model update just after the rising edge.
    initial begin
        int n, blk, w, j, k;
        logic [DW-1:0] ea, eb;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (fgen[i] != fseen[i]) begin
                    fseen[i] = fgen[i];
                    a_rd[i] = a_wr[i]; b_rd[i] = b_wr[i];
                    a_base[i] = a_wr[i]; b_base[i] = b_wr[i];
                    fa_n[i] = 0; fb_n[i] = 0; pair_n[i] = 0;
                    pend_a[i] = 0; pend_b[i] = 0; hold[i] = 0; rel[i] = 0;
                end
                chk("wr_a", 64'(wr_a[i]), 64'(pend_a[i]));
                if (pend_a[i]) begin
                    chk("fwd_a", 64'(fa_d[i]), 64'(aw[i][(a_base[i] + fa_n[i]) & M]));
                    fa_n[i]++;
                end
                chk("wr_b", 64'(wr_b[i]), 64'(pend_b[i]));
                if (pend_b[i]) begin
                    chk("fwd_b", 64'(fb_d[i]), 64'(bw[i][(b_base[i] + fb_n[i]) & M]));
                    fb_n[i]++;
                end
                if (hold[i]) chk("hold", 64'({val[i], last[i], idx[i], da[i], db[i]}), held[i]);
                if (rel[i] && va[i] && !(i == 0 && full_a[i])) chk("resume", 64'(rd_a[i]), 64'(1));
                if (i == 0 && full_a[i]) chk("bp_a", 64'(rd_a[i]), 64'(0));
                if (i == 0 && full_b[i]) chk("bp_b", 64'(rd_b[i]), 64'(0));
                if (val[i] && rdy[i]) begin
                    n = pair_n[i];
                    blk = n / (PN * BN); w = n % (PN * BN); j = w / PN; k = w % PN;
                    ea = aw[i][(a_base[i] + blk * AT + PID * PN + k) & M];
                    eb = bw[i][(b_base[i] + blk * BN + j) & M];
                    chk("pair_a", 64'(da[i]), 64'(ea));
                    chk("pair_b", 64'(db[i]), 64'(eb));
                    chk("pair_idx", 64'(idx[i]), 64'(k));
                    chk("pair_last", 64'(last[i]), 64'(k == PN - 1 && j == BN - 1));
                    pair_n[i]++;
                end
                hold[i] = val[i] && !rdy[i];
                held[i] = 64'({val[i], last[i], idx[i], da[i], db[i]});
                rel[i] = val[i] && rdy[i] && last[i];
                pend_a[i] = rd_a[i] && i == 0;
                pend_b[i] = rd_b[i] && i == 0;
                popa[i] = rd_a[i];
                popb[i] = rd_b[i];
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (popa[i]) begin a_rd[i]++; a_pop[i]++; end
                if (popb[i]) b_rd[i]++;
                va[i] = a_rd[i] != a_wr[i];
                vb[i] = b_rd[i] != b_wr[i];
                dai[i] = aw[i][a_rd[i] & M];
                dbi[i] = bw[i][b_rd[i] & M];
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic push_a(input int i, input logic [DW-1:0] d);
        aw[i][a_wr[i] & M] = d;
        a_wr[i]++;
    endtask

    task automatic push_b(input int i, input logic [DW-1:0] d);
        bw[i][b_wr[i] & M] = d;
        b_wr[i]++;
        tgt[i] += PN;
    endtask

    task automatic wait_done(input int i);
        int t = 0;
        while (pair_n[i] < tgt[i] && t < 400) begin step(1); t++; end
        chk("drain", 64'(pair_n[i]), 64'(tgt[i]));
    endtask

    task automatic chk_zero(input int i);
        chk("rst_ctl", 64'({rd_a[i], wr_a[i], rd_b[i], wr_b[i], val[i], last[i], idx[i]}), 64'(0));
        chk("rst_pair", 64'({da[i], db[i]}), 64'(0));
        chk("rst_fwd", 64'({fa_d[i], fb_d[i]}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int start, t;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            va[i] = 0; vb[i] = 0; dai[i] = '0; dbi[i] = '0;
            full_a[i] = i == 1; full_b[i] = i == 1; rdy[i] = 1;
            a_wr[i] = 0; b_wr[i] = 0; a_rd[i] = 0; b_rd[i] = 0; a_base[i] = 0; b_base[i] = 0;
            fa_n[i] = 0; fb_n[i] = 0; pair_n[i] = 0; a_pop[i] = 0; tgt[i] = 0; fgen[i] = 0; fseen[i] = 0;
        end
        #1;
        chk_zero(0);
        chk_zero(1);
        step(2);
        rst = 1'b0;
        step(2);

        // Basic pairing with fixed values
        for (int w = 10; w < 14; w++) push_a(0, DW'(w));
        push_b(0, 16'd100);
        push_b(0, 16'd101);
        wait_done(0);

        // Ping-pong: two blocks load back-to-back, the third stalls until a release
        start = a_pop[0];
        for (int w = 0; w < 3 * AT; w++) push_a(0, DW'($urandom));
        step(9);
        chk("pp_nostall", 64'(a_pop[0] - start), 64'(2 * AT));
        step(10);
        chk("pp_stall", 64'(a_pop[0] - start), 64'(2 * AT));
        chk("pp_rd_low", 64'(rd_a[0]), 64'(0));
        for (int w = 0; w < 3 * BN; w++) push_b(0, DW'($urandom));
        wait_done(0);
        chk("pp_all", 64'(a_pop[0] - start), 64'(3 * AT));

        // Downstream A backpressure mid-block
        for (int w = 0; w < AT; w++) push_a(0, DW'($urandom));
        step(3);
        full_a[0] = 1;
        step(5);
        full_a[0] = 0;
        for (int w = 0; w < BN; w++) push_b(0, DW'($urandom));
        wait_done(0);

        // MAC backpressure on the idx-1 pair of the first B word
        for (int w = 20; w < 24; w++) push_a(0, DW'(w));
        push_b(0, 16'd200);
        push_b(0, 16'd201);
        t = 0;
        while (!(val[0] && idx[0] == 1'b1) && t < 100) begin step(1); t++; end
        chk("mac_reach", 64'(val[0] && idx[0] == 1'b1), 64'(1));
        rdy[0] = 0;
        step(3);
        rdy[0] = 1;
        wait_done(0);

        // Reset while a pair is stalled in EMIT and the next block is partly loaded
        rdy[0] = 0;
        start = a_pop[0];
        for (int w = 0; w < AT; w++) push_a(0, DW'($urandom));
        for (int w = 0; w < BN; w++) push_b(0, DW'($urandom));
        for (int w = 0; w < AT; w++) push_a(0, DW'($urandom));
        t = 0;
        while (a_pop[0] - start < AT + 3 && t < 100) begin step(1); t++; end
        chk("rst_reach", 64'(a_pop[0] - start), 64'(AT + 3));
        chk("rst_emit", 64'(val[0]), 64'(1));
        rst = 1'b1;
        fgen[0]++; fgen[1]++;
        tgt[0] = 0; tgt[1] = 0;
        #1;
        chk_zero(0);
        step(2);
        rst = 1'b0;
        rdy[0] = 1;
        step(2);
        for (int w = 0; w < AT; w++) push_a(0, DW'($urandom));
        for (int w = 0; w < BN; w++) push_b(0, DW'($urandom));
        wait_done(0);

        // Last PE: both full inputs held high, no forwarding
        for (int w = 0; w < 2 * AT; w++) push_a(1, DW'($urandom));
        for (int w = 0; w < 2 * BN; w++) push_b(1, DW'($urandom));
        wait_done(1);

        // Randomized backpressure on all three interfaces
        for (int w = 0; w < 3 * AT; w++) push_a(0, DW'($urandom));
        for (int w = 0; w < 3 * BN; w++) push_b(0, DW'($urandom));
        t = 0;
        while (pair_n[0] < tgt[0] && t < 600) begin
            full_a[0] = $urandom_range(3) == 0;
            full_b[0] = $urandom_range(3) == 0;
            rdy[0] = $urandom_range(3) != 0;
            step(1);
            t++;
        end
        full_a[0] = 0; full_b[0] = 0; rdy[0] = 1;
        wait_done(0);
        step(3);
        chk("fwd_a_total", 64'(fa_n[0]), 64'(a_wr[0] - a_base[0]));
        chk("fwd_b_total", 64'(fb_n[0]), 64'(b_wr[0] - b_base[0]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
